// File: rtl/rs_pkg.sv
// rs_pkg: shared constants and FSM state types for the RS de-interleave scheduler
package rs_pkg;
    localparam int I_DEPTH    = 4;
    localparam int CW_LEN     = 255;
    localparam int FRAME_LEN  = I_DEPTH * CW_LEN;
    localparam int CW_IDX_W   = 2;
    localparam int SYM_ADDR_W = 8;
    localparam int POS_W      = CW_IDX_W + SYM_ADDR_W;

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_SKIP} wr_state_t;
    typedef enum logic [1:0] {D_IDLE, D_START, D_WAIT} dec_state_t;
endpackage

// File: rtl/rs_deint_scheduler_if.sv
// rs_deint_scheduler_if: byte stream in, bank write bus, RS decoder handshake and status.
// master drives the stream and decoder responses; slave is the scheduler.
interface rs_deint_scheduler_if;
    import rs_pkg::*;
    logic                  new_cvcdu;
    logic                  symbol_valid_in;
    logic [7:0]            symbol_in;
    logic                  wr_en_out;
    logic                  wr_bank_out;
    logic [CW_IDX_W-1:0]   wr_cw_out;
    logic [SYM_ADDR_W-1:0] wr_addr_out;
    logic [7:0]            wr_data_out;
    logic                  dec_start_out;
    logic                  dec_bank_out;
    logic [CW_IDX_W-1:0]   dec_cw_out;
    logic                  dec_ready_in;
    logic                  dec_done_in;
    logic                  frame_drop_out;
    logic                  short_frame_out;
    logic                  busy_out;

    modport master (
        output new_cvcdu, symbol_valid_in, symbol_in, dec_ready_in, dec_done_in,
        input  wr_en_out, wr_bank_out, wr_cw_out, wr_addr_out, wr_data_out,
               dec_start_out, dec_bank_out, dec_cw_out, frame_drop_out, short_frame_out, busy_out
    );
    modport slave (
        input  new_cvcdu, symbol_valid_in, symbol_in, dec_ready_in, dec_done_in,
        output wr_en_out, wr_bank_out, wr_cw_out, wr_addr_out, wr_data_out,
               dec_start_out, dec_bank_out, dec_cw_out, frame_drop_out, short_frame_out, busy_out
    );
endinterface

// File: rtl/rs_dispatch_fsm.sv
// rs_dispatch_fsm: hands the four codewords of each full bank to the RS decoder, oldest bank first.
// Ports: clk/rst; full[1:0] bank-full flags in; dec_ready/dec_done decoder handshake in;
// dec_start/dec_bank/dec_cw to the decoder; free_pulse/free_bank release a decoded bank.
module rs_dispatch_fsm
    import rs_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          full,
    input  logic                dec_ready,
    input  logic                dec_done,
    output logic                dec_start,
    output logic                dec_bank,
    output logic [CW_IDX_W-1:0] dec_cw,
    output logic                free_pulse,
    output logic                free_bank
);
    dec_state_t          state, state_n;
    logic                rd_bank, rd_bank_n;
    logic [CW_IDX_W-1:0] cw, cw_n;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= D_IDLE;
            rd_bank <= 1'b0;
            cw      <= '0;
        end else begin
            state   <= state_n;
            rd_bank <= rd_bank_n;
            cw      <= cw_n;
        end

    always_comb begin
        state_n    = state;
        rd_bank_n  = rd_bank;
        cw_n       = cw;
        dec_start  = 1'b0;
        free_pulse = 1'b0;
        case (state)
            D_IDLE:
                if (full[rd_bank]) begin
                    cw_n    = '0;
                    state_n = D_START;
                end
            D_START:
                if (dec_ready) begin
                    dec_start = 1'b1;
                    state_n   = D_WAIT;
                end
            D_WAIT:
                if (dec_done) begin
                    if (cw == CW_IDX_W'(I_DEPTH - 1)) begin
                        free_pulse = 1'b1;
                        rd_bank_n  = ~rd_bank;
                        state_n    = D_IDLE;
                    end else begin
                        cw_n    = cw + CW_IDX_W'(1);
                        state_n = D_START;
                    end
                end
            default: state_n = D_IDLE;
        endcase
    end

    // bank/cw are registers that only move in IDLE or on done, so they hold through each decode
    assign dec_bank  = rd_bank;
    assign dec_cw    = cw;
    assign free_bank = rd_bank;
endmodule

// File: rtl/rs_deint_scheduler.sv
// rs_deint_scheduler: de-interleaves CVCDU bytes into ping-pong codeword banks and schedules RS decoding.
// Ports: clk_in, rst_in (async, active high); bus (slave): byte stream in, registered bank write
// strobe/bank/cw/addr/data, decoder start/bank/cw with ready/done, drop/short pulses, busy.
module rs_deint_scheduler
    import rs_pkg::*;
(
    input logic                 clk_in,
    input logic                 rst_in,
    rs_deint_scheduler_if.slave bus
);
    wr_state_t        state, state_n;
    logic [POS_W-1:0] pos, pos_n, cur_pos;
    logic [1:0]       full, full_n;
    logic             wr_bank, wr_bank_n;
    logic             start_ok, drop, short_n, acc, last;
    logic             free_pulse, free_bank;

    always_comb begin
        // in FILL the bank being written is never full, so start_ok also covers the restart case
        start_ok  = bus.new_cvcdu && !full[wr_bank];
        drop      = bus.new_cvcdu && full[wr_bank];
        short_n   = bus.new_cvcdu && state == W_FILL;
        acc       = bus.symbol_valid_in && (state == W_FILL || start_ok);
        cur_pos   = start_ok ? '0 : pos;
        last      = acc && cur_pos == POS_W'(FRAME_LEN - 1);
        state_n   = state;
        pos_n     = pos;
        wr_bank_n = wr_bank;
        full_n    = full;
        if (free_pulse)
            full_n[free_bank] = 1'b0;
        if (drop)
            state_n = W_SKIP;
        else if (start_ok) begin
            state_n = W_FILL;
            pos_n   = '0;
        end
        if (acc)
            pos_n = cur_pos + POS_W'(1);
        if (last) begin
            full_n[wr_bank] = 1'b1;
            wr_bank_n       = ~wr_bank;
            state_n         = W_IDLE;
            pos_n           = '0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in)
        if (rst_in) begin
            state               <= W_IDLE;
            pos                 <= '0;
            full                <= '0;
            wr_bank             <= 1'b0;
            bus.wr_en_out       <= 1'b0;
            bus.wr_bank_out     <= 1'b0;
            bus.wr_cw_out       <= '0;
            bus.wr_addr_out     <= '0;
            bus.wr_data_out     <= '0;
            bus.frame_drop_out  <= 1'b0;
            bus.short_frame_out <= 1'b0;
        end else begin
            state               <= state_n;
            pos                 <= pos_n;
            full                <= full_n;
            wr_bank             <= wr_bank_n;
            bus.wr_en_out       <= acc;
            bus.frame_drop_out  <= drop;
            bus.short_frame_out <= short_n;
            if (acc) begin
                bus.wr_bank_out <= wr_bank;
                bus.wr_cw_out   <= cur_pos[CW_IDX_W-1:0];
                bus.wr_addr_out <= cur_pos[POS_W-1:CW_IDX_W];
                bus.wr_data_out <= bus.symbol_in;
            end
        end

    assign bus.busy_out = state == W_FILL || |full;

    rs_dispatch_fsm u_dispatch (
        .clk        (clk_in),
        .rst        (rst_in),
        .full       (full),
        .dec_ready  (bus.dec_ready_in),
        .dec_done   (bus.dec_done_in),
        .dec_start  (bus.dec_start_out),
        .dec_bank   (bus.dec_bank_out),
        .dec_cw     (bus.dec_cw_out),
        .free_pulse (free_pulse),
        .free_bank  (free_bank)
    );
endmodule

// File: tb/tb_rs_deint_scheduler.sv
// tb_rs_deint_scheduler: vector table, frame-level reference model and reset corner cases for the scheduler
module tb_rs_deint_scheduler;
    import rs_pkg::*;

    typedef struct packed {logic bank; logic [1:0] cw; logic [7:0] addr; logic [7:0] data;} wr_t;
    typedef struct packed {logic bank; logic [1:0] cw;} st_t;
    typedef struct {
        logic ncv; logic v; logic [7:0] d;
        logic e_en; logic [1:0] e_cw; logic [7:0] e_addr; logic e_short;
    } vec_t;

    localparam int DONE_DLY = 10;

    logic clk = 0;
    logic rst = 1;
    logic auto_done = 0;
    logic stray_done = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    rs_deint_scheduler_if bus();
    assign bus.dec_done_in = auto_done | stray_done;

    rs_deint_scheduler dut (.clk_in(clk), .rst_in(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    wr_t  got_wr[$], exp_wr[$];
    st_t  got_st[$], exp_st[$];
    int   lens[$];
    int   n_drop = 0, n_short = 0, stab_err = 0;
    int   wbase, sbase, d0, s0, stab0, e_drop, e_short;
    bit   m_fill;
    bit   in_flight = 0;
    st_t  fl;
    vec_t tbl[12];

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [26:0] outs();
        return {bus.wr_en_out, bus.wr_bank_out, bus.wr_cw_out, bus.wr_addr_out, bus.wr_data_out,
                bus.dec_start_out, bus.dec_bank_out, bus.dec_cw_out, bus.frame_drop_out,
                bus.short_frame_out, bus.busy_out};
    endfunction

    function automatic vec_t mk(input logic ncv, input logic v, input logic [7:0] d, input logic e_en,
                                input logic [1:0] e_cw, input logic [7:0] e_addr, input logic e_short);
        vec_t r;
        r.ncv = ncv; r.v = v; r.d = d; r.e_en = e_en; r.e_cw = e_cw; r.e_addr = e_addr; r.e_short = e_short;
        return r;
    endfunction

    // decoder model: done pulse DONE_DLY cycles after each start
    initial forever begin
        @(negedge clk);
        if (bus.dec_start_out && !rst) begin
            repeat (DONE_DLY) @(posedge clk);
            #1 auto_done = 1;
            @(posedge clk);
            #1 auto_done = 0;
        end
    end

    // observer: logs writes, starts, pulses and checks decoder outputs hold until done
    initial forever begin
        @(negedge clk);
        if (rst) in_flight = 0;
        else begin
            if (bus.wr_en_out) got_wr.push_back({bus.wr_bank_out, bus.wr_cw_out, bus.wr_addr_out, bus.wr_data_out});
            if (bus.frame_drop_out) n_drop++;
            if (bus.short_frame_out) n_short++;
            if (in_flight && (bus.dec_bank_out !== fl.bank || bus.dec_cw_out !== fl.cw)) stab_err++;
            if (in_flight && bus.dec_done_in) in_flight = 0;
            if (bus.dec_start_out) begin
                fl = {bus.dec_bank_out, bus.dec_cw_out};
                got_st.push_back(fl);
                in_flight = 1;
            end
        end
    end

    task automatic assert_rst();
        rst = 1;
        bus.new_cvcdu = 0; bus.symbol_valid_in = 0; bus.symbol_in = 0; bus.dec_ready_in = 0;
    endtask

    task automatic release_rst();
        repeat (15) @(posedge clk);
        #1 rst = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 assert_rst();
        release_rst();
    endtask

    // frame-level model: each new_cvcdu either restarts an unfinished frame (short), is dropped when
    // both banks hold undecoded frames, or starts in the next bank; byte k lands at cw k%4, addr k/4
    task automatic feed_frames(input bit rdy, input bit gaps);
        int nfull;
        logic wb;
        bit acc;
        logic [7:0] d;
        exp_wr.delete(); exp_st.delete();
        e_drop = 0; e_short = 0; m_fill = 0; nfull = 0; wb = 0;
        wbase = got_wr.size(); sbase = got_st.size(); d0 = n_drop; s0 = n_short; stab0 = stab_err;
        bus.dec_ready_in = rdy;
        foreach (lens[f]) begin
            acc = 1;
            if (m_fill) e_short++;
            else if (nfull == 2) begin e_drop++; acc = 0; end
            m_fill = acc;
            for (int k = 0; k < lens[f]; k++) begin
                d = 8'(k + 37 * f);
                bus.new_cvcdu = (k == 0); bus.symbol_valid_in = 1; bus.symbol_in = d;
                @(posedge clk);
                #1 bus.new_cvcdu = 0; bus.symbol_valid_in = 0;
                if (gaps && $urandom_range(2) == 0) begin
                    bus.symbol_in = 8'($urandom);
                    @(posedge clk);
                    #1;
                end
                if (acc) exp_wr.push_back({wb, 2'(k % 4), 8'(k / 4), d});
            end
            if (acc && lens[f] == FRAME_LEN) begin
                nfull++;
                for (int c = 0; c < I_DEPTH; c++) exp_st.push_back({wb, 2'(c)});
                wb = ~wb;
                m_fill = 0;
            end
            repeat (2) @(posedge clk);
            #1;
        end
        if (!rdy) begin
            stray_done = 1;
            @(posedge clk);
            #1 stray_done = 0;
        end
        bus.dec_ready_in = 1;
    endtask

    task automatic finish_check(input string nm);
        int t, bad;
        t = 0;
        while (got_st.size() - sbase < exp_st.size() && t < 4000) begin @(posedge clk); #1; t++; end
        check({nm, "_start_wait"}, t < 4000, 1);
        if (exp_st.size() > 0) check({nm, "_busy_in_dec"}, bus.busy_out, 1);
        t = 0;
        while (bus.busy_out !== m_fill && t < 200) begin @(posedge clk); #1; t++; end
        repeat (3) @(posedge clk);
        #1;
        check({nm, "_busy_end"}, bus.busy_out, m_fill);
        check({nm, "_wr_count"}, got_wr.size() - wbase, exp_wr.size());
        bad = -1;
        for (int i = 0; i < exp_wr.size(); i++)
            if (bad < 0 && wbase + i < got_wr.size() && got_wr[wbase + i] !== exp_wr[i]) bad = i;
        check({nm, "_wr_first_bad"}, bad, -1);
        check({nm, "_start_count"}, got_st.size() - sbase, exp_st.size());
        bad = -1;
        for (int i = 0; i < exp_st.size(); i++)
            if (bad < 0 && sbase + i < got_st.size() && got_st[sbase + i] !== exp_st[i]) bad = i;
        check({nm, "_start_first_bad"}, bad, -1);
        check({nm, "_drops"}, n_drop - d0, e_drop);
        check({nm, "_shorts"}, n_short - s0, e_short);
        check({nm, "_dec_stable"}, stab_err - stab0, 0);
    endtask

    initial begin
        int t;
        logic [26:0] pre;
        tbl[0]  = mk(1, 1, 8'hA0, 1, 0, 0, 0);
        tbl[1]  = mk(0, 0, 8'hFF, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 8'hA1, 1, 1, 0, 0);
        tbl[3]  = mk(0, 1, 8'hA2, 1, 2, 0, 0);
        tbl[4]  = mk(0, 0, 8'h55, 0, 0, 0, 0);
        tbl[5]  = mk(0, 1, 8'hA3, 1, 3, 0, 0);
        tbl[6]  = mk(0, 1, 8'hA4, 1, 0, 1, 0);
        tbl[7]  = mk(1, 1, 8'hA5, 1, 0, 0, 1);
        tbl[8]  = mk(0, 1, 8'hA6, 1, 1, 0, 0);
        tbl[9]  = mk(0, 0, 8'h00, 0, 0, 0, 0);
        tbl[10] = mk(1, 0, 8'h77, 0, 0, 0, 1);
        tbl[11] = mk(0, 1, 8'hA7, 1, 0, 0, 0);

        assert_rst();
        @(posedge clk);
        #1 check("reset_outputs", outs(), 0);
        release_rst();

        // single-cycle behaviour: gaps, one-cycle latency, restarts with and without a byte
        foreach (tbl[i]) begin
            bus.new_cvcdu = tbl[i].ncv; bus.symbol_valid_in = tbl[i].v; bus.symbol_in = tbl[i].d;
            @(posedge clk);
            #1;
            check($sformatf("table_row%0d", i),
                  {bus.wr_en_out, tbl[i].e_en ? {bus.wr_bank_out, bus.wr_cw_out, bus.wr_addr_out, bus.wr_data_out} : 19'd0,
                   bus.short_frame_out, bus.busy_out},
                  {tbl[i].e_en, tbl[i].e_en ? {1'b0, tbl[i].e_cw, tbl[i].e_addr, tbl[i].d} : 19'd0,
                   tbl[i].e_short, 1'b1});
        end
        bus.new_cvcdu = 0; bus.symbol_valid_in = 0;

        do_reset();
        lens = '{FRAME_LEN};
        feed_frames(1, 0);
        finish_check("full");
        check("full_last_write", got_wr[wbase + FRAME_LEN - 1], {1'b0, 2'd3, 8'd254, 8'hFB});
        t = got_st.size();
        stray_done = 1;
        @(posedge clk);
        #1 stray_done = 0;
        repeat (5) @(posedge clk);
        #1;
        check("stray_done_starts", got_st.size() - t, 0);
        check("stray_done_busy", bus.busy_out, 0);

        do_reset();
        lens = '{FRAME_LEN, FRAME_LEN, 10};
        feed_frames(0, 0);
        finish_check("stall");

        do_reset();
        lens = '{500, FRAME_LEN};
        feed_frames(1, 0);
        finish_check("short");
        check("short_restart_pos0", got_wr[wbase + 500], {1'b0, 2'd0, 8'd0, 8'(37)});

        for (int r = 0; r < 3; r++) begin
            do_reset();
            lens.delete();
            for (int f = 0; f < 4; f++)
                lens.push_back($urandom_range(1) ? FRAME_LEN : int'($urandom_range(1, FRAME_LEN - 1)));
            feed_frames(0, 1);
            finish_check($sformatf("rand%0d", r));
        end

        // async reset in the middle of a fill
        do_reset();
        lens = '{600};
        feed_frames(1, 0);
        check("midfill_wr_count", got_wr.size() - wbase, 600);
        check("midfill_last_write", got_wr[got_wr.size() - 1], {1'b0, 2'd3, 8'd149, 8'(599)});
        pre = outs();
        check("midfill_busy_before", pre[0], 1);
        #2 assert_rst();
        #1 check("midfill_async_zero", outs(), 0);
        release_rst();
        lens = '{FRAME_LEN};
        feed_frames(1, 0);
        finish_check("after_fill_rst");

        // async reset in the middle of decoding codeword 2
        do_reset();
        lens = '{FRAME_LEN};
        feed_frames(1, 0);
        t = 0;
        while (got_st.size() - sbase < 3 && t < 500) begin @(posedge clk); #1; t++; end
        check("middec_reach_cw2", t < 500, 1);
        repeat (3) @(posedge clk);
        #1 check("middec_state", {bus.dec_bank_out, bus.dec_cw_out, bus.busy_out}, {1'b0, 2'd2, 1'b1});
        #2 assert_rst();
        #1 check("middec_async_zero", outs(), 0);
        t = got_st.size();
        release_rst();
        repeat (20) @(posedge clk);
        #1 check("middec_no_resume", got_st.size() - t, 0);
        check("middec_idle_busy", bus.busy_out, 0);
        lens = '{FRAME_LEN};
        feed_frames(1, 0);
        finish_check("after_dec_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rs_deint_scheduler.md
Name: rs_deint_scheduler

Overview:
- Sequencing controller for the RS de-interleaving stage of the LRPT decoder.
- Accepts the byte stream of each CVCDU after sync removal: 1020 bytes, interleave depth 4, four RS(255,223) codewords.
- Writes each byte into one of two ping-pong codeword banks at (codeword, symbol index).
- Once a bank holds a complete CVCDU, dispatches its four codewords one at a time to the shared RS decoder using a start/ready/done handshake.

Parameters:
- I_DEPTH, 4, interleave depth; codeword select is pos mod I_DEPTH. Must be a power of 2.
- CW_LEN, 255, symbols per codeword; frame length is I_DEPTH*CW_LEN = 1020.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-high reset
- new_cvcdu  input  1  one-cycle pulse marking the first byte of a CVCDU
- symbol_valid_in  input  1  symbol_in is valid this cycle
- symbol_in  input  8  received byte
- wr_en_out  output  1  bank write strobe
- wr_bank_out  output  1  bank being written
- wr_cw_out  output  2  codeword index (pos mod 4)
- wr_addr_out  output  8  symbol index within codeword (pos div 4)
- wr_data_out  output  8  registered copy of symbol_in
- dec_start_out  output  1  one-cycle start pulse to the RS decoder
- dec_bank_out  output  1  bank being decoded
- dec_cw_out  output  2  codeword being decoded
- dec_ready_in  input  1  decoder can accept a start
- dec_done_in  input  1  decoder finished the current codeword (pulse)
- frame_drop_out  output  1  pulse: CVCDU dropped because no bank was free
- short_frame_out  output  1  pulse: CVCDU aborted before 1020 bytes
- busy_out  output  1  write FSM in FILL, or any bank full or decoding

Behaviour:
- Reset: asynchronous, active-high. Clears every register and output to 0, both bank-full flags to 0, both bank pointers to bank 0, and both FSMs to IDLE. Reset mid-frame or mid-decode abandons all work.
- Accept condition: a byte is accepted when symbol_valid_in=1 and the write FSM is in FILL, or when the same cycle carries a new_cvcdu that is being accepted.
- Write FSM, states W_IDLE, W_FILL, W_SKIP:
  - W_IDLE + new_cvcdu:
    - If !full[wr_bank], go to W_FILL with pos=0. A valid byte in the same cycle is pos 0.
    - Else pulse frame_drop_out and go to W_SKIP.
  - W_FILL, per accepted byte: wr_cw=pos[1:0], wr_addr=pos[9:2], then pos++.
  - W_FILL, accepting pos=1019: set full[wr_bank], toggle wr_bank, return to W_IDLE.
  - W_FILL + new_cvcdu before pos 1019: pulse short_frame_out. Discard the partial bank (full flag stays 0) and restart at pos=0 in the same bank; a valid byte in that cycle is the new pos 0.
  - W_SKIP: ignore bytes. new_cvcdu is evaluated exactly as in W_IDLE.
  - W_IDLE: bytes without new_cvcdu are ignored.
- Write latency: wr_en/cw/addr/data/bank are registered and appear exactly 1 cycle after the accepting edge. wr_en_out is high for one cycle per accepted byte.
- Decode FSM, states D_IDLE, D_START, D_WAIT; rd_bank pointer and cw counter:
  - D_IDLE: if full[rd_bank], set cw=0 and go to D_START.
  - D_START: when dec_ready_in=1, pulse dec_start_out for 1 cycle with dec_bank_out=rd_bank and dec_cw_out=cw, then go to D_WAIT. If not ready, hold with no pulse.
  - D_WAIT on dec_done_in: if cw<3, increment cw and go to D_START. If cw=3, clear full[rd_bank], toggle rd_bank, and go to D_IDLE.
  - dec_done_in outside D_WAIT is ignored.
  - dec_bank_out/dec_cw_out stay stable from the start pulse until done.
- Simultaneous events:
  - Set of full[wr_bank] and clear of full[rd_bank] in one cycle target different banks. Both take effect.
  - A bank freed in cycle N is writable by a new_cvcdu in cycle N+1, not N.
- Ordering: banks are decoded strictly in fill order (oldest first).
- Arithmetic: pos is 10 bits and compares against I_DEPTH*CW_LEN-1. It never wraps past 1019.

Decomposition:
- Package rs_pkg holds:
  - constants I_DEPTH, CW_LEN, FRAME_LEN=1020, CW_IDX_W=2, SYM_ADDR_W=8
  - typedef enum wr_state_t {W_IDLE, W_FILL, W_SKIP}
  - typedef enum dec_state_t {D_IDLE, D_START, D_WAIT}
- One natural sub-module: rs_dispatch_fsm, the decode-side FSM with its rd_bank and cw counters. It takes full[1:0] in and gives free_pulse/free_bank out.

Test Plan:
- Full frame: new_cvcdu plus 1020 valid bytes 0x00..0xFB (mod 256), dec_ready_in=1, done returned 10 cycles after each start.
  - Byte k writes cw=k%4, addr=k/4, 1 cycle late; byte 1019 goes to cw=3, addr=254, bank 0.
  - Then 4 start pulses with cw 0,1,2,3 on bank 0, after which busy_out falls.
- Back-to-back frames with decoder stalled (dec_ready_in=0): frame 1 fills bank 0 and frame 2 fills bank 1. Frame 3's new_cvcdu gives frame_drop_out=1 and no wr_en. After ready=1, bank 0 is decoded before bank 1.
- Short frame: new_cvcdu, 500 bytes, new_cvcdu, 1020 bytes.
  - short_frame_out pulses once; the restart writes pos 0 to bank 0, cw=0, addr=0.
  - Only one bank goes full, with exactly 4 starts.
- Gapped input: symbol_valid_in toggling 1/0 → wr_en_out follows with 1-cycle latency and addresses stay contiguous. Stray dec_done_in in D_IDLE causes no state change.
- Async reset asserted mid-fill (pos=600) and mid-decode (cw=2): all outputs 0 immediately, with no clock edge needed. After release, a new frame starts in bank 0 at pos 0.
